// File: rtl/win_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : win_scan_controller
// Description : Checks for a Connect Four win after each drop. It walks the
//               board through a single read port that it shares with the VGA
//               renderer. The renderer always has priority on that port, and
//               the scanner only reads while disp_active is low. The module
//               also drives the sticky game_over/winner flags.
// Ports       : clk_25MHz, rst_n (async, active-low)
//               new_game, check_start, check_row/col   - game control
//               disp_active, disp_row/col, disp_data   - renderer side
//               board_data, row_read/col_read          - board memory port
//               busy, game_over, winner                - status
// Options     : WIN_SCAN_DRAW_EN - when defined, a drop counter is kept and
//               a full board with no win reports a draw (winner = 2'b11).
// Revision    : 1.0 - initial release
// ============================================================================
module win_scan_controller #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int WIN_LEN = 4
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       check_start,
    input  logic [2:0] check_row,
    input  logic [2:0] check_col,
    input  logic       disp_active,
    input  logic [2:0] disp_row,
    input  logic [2:0] disp_col,
    input  logic [1:0] board_data,
    output logic [2:0] row_read,
    output logic [2:0] col_read,
    output logic [1:0] disp_data,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ORIGIN = 2'd1,
        ST_WALK   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Direction order: H(0,+1), V(+1,0), D1(+1,+1), D2(+1,-1)
    localparam logic [1:0] c_DIR_H  = 2'd0;
    localparam logic [1:0] c_DIR_V  = 2'd1;
    localparam logic [1:0] c_DIR_D2 = 2'd3;
    localparam logic [2:0] c_WIN    = 3'(WIN_LEN);
    localparam logic [2:0] c_K_MAX  = 3'(WIN_LEN - 1);
    localparam logic [3:0] c_ROWS4  = 4'(ROWS);
    localparam logic [3:0] c_COLS4  = 4'(COLS);

    state_t     state_q,     state_d;
    logic [2:0] org_row_q,   org_row_d;
    logic [2:0] org_col_q,   org_col_d;
    logic [1:0] player_q,    player_d;
    logic [2:0] count_q,     count_d;
    logic [2:0] k_q,         k_d;
    logic [1:0] dir_q,       dir_d;
    logic       sign_q,      sign_d;      // 0 = + side, 1 = - side
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q,    winner_d;
`ifdef WIN_SCAN_DRAW_EN
    localparam logic [6:0] c_CELLS = 7'(ROWS * COLS);
    logic [6:0] drop_q, drop_d;
`endif

    // Walk cell = origin + sign*k*dir. The 4-bit signed sum can wrap for
    // cells past the top/right edge, but any wrapped value comes out
    // negative, so the bounds test still rejects it.
    logic signed [3:0] w_k, w_step, w_row_off, w_col_off;
    logic signed [3:0] w_cell_row, w_cell_col;
    logic              w_in_bounds, w_reading, w_end_sign;

    always_comb begin
        w_k       = signed'({1'b0, k_q});
        w_step    = sign_q ? -w_k : w_k;
        w_row_off = (dir_q == c_DIR_H) ? 4'sd0 : w_step;
        if (dir_q == c_DIR_V)
            w_col_off = 4'sd0;
        else if (dir_q == c_DIR_D2)
            w_col_off = -w_step;
        else
            w_col_off = w_step;
        w_cell_row  = signed'({1'b0, org_row_q}) + w_row_off;
        w_cell_col  = signed'({1'b0, org_col_q}) + w_col_off;
        w_in_bounds = !w_cell_row[3] && ({1'b0, w_cell_row[2:0]} < c_ROWS4) &&
                      !w_cell_col[3] && ({1'b0, w_cell_col[2:0]} < c_COLS4);
        w_reading   = (state_q == ST_ORIGIN) || ((state_q == ST_WALK) && w_in_bounds);
    end

    // Shared port: the renderer wins whenever it asks for the port.
    always_comb begin
        row_read = disp_row;
        col_read = disp_col;
        if (w_reading && !disp_active) begin
            row_read = (state_q == ST_ORIGIN) ? org_row_q : w_cell_row[2:0];
            col_read = (state_q == ST_ORIGIN) ? org_col_q : w_cell_col[2:0];
        end
    end

    assign disp_data = board_data;
    assign busy      = (state_q != ST_IDLE);
    assign game_over = game_over_q;
    assign winner    = winner_q;

    always_comb begin
        state_d     = state_q;
        org_row_d   = org_row_q;
        org_col_d   = org_col_q;
        player_d    = player_q;
        count_d     = count_q;
        k_d         = k_q;
        dir_d       = dir_q;
        sign_d      = sign_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        w_end_sign  = 1'b0;
`ifdef WIN_SCAN_DRAW_EN
        drop_d      = drop_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (check_start && !game_over_q) begin
                    org_row_d = check_row;
                    org_col_d = check_col;
                    count_d   = 3'd0;
                    state_d   = ST_ORIGIN;
`ifdef WIN_SCAN_DRAW_EN
                    drop_d    = drop_q + 7'd1;
`endif
                end
            end
            ST_ORIGIN: begin
                if (!disp_active) begin
                    player_d = board_data;
                    if (board_data == 2'b00) begin
                        state_d = ST_DONE;         // empty origin: nothing to check
                    end else begin
                        count_d = 3'd1;
                        dir_d   = c_DIR_H;
                        sign_d  = 1'b0;
                        k_d     = 3'd1;
                        state_d = ST_WALK;
                    end
                end
            end
            ST_WALK: begin
                if (!w_in_bounds) begin
                    w_end_sign = 1'b1;
                end else if (!disp_active) begin
                    if (board_data == player_q) begin
                        count_d = count_q + 3'd1;
                        if ((count_q + 3'd1) == c_WIN)
                            state_d = ST_DONE;
                        else if (k_q == c_K_MAX)
                            w_end_sign = 1'b1;
                        else
                            k_d = k_q + 3'd1;
                    end else begin
                        w_end_sign = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (count_q == c_WIN) begin
                    game_over_d = 1'b1;
                    winner_d    = player_q;
                end
`ifdef WIN_SCAN_DRAW_EN
                else if (drop_q == c_CELLS) begin
                    game_over_d = 1'b1;
                    winner_d    = 2'b11;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // The + side keeps its count for the - side. After the - side the
        // next direction starts over from the origin alone.
        if (w_end_sign) begin
            k_d = 3'd1;
            if (!sign_q) begin
                sign_d = 1'b1;
            end else if (dir_q == c_DIR_D2) begin
                state_d = ST_DONE;
            end else begin
                dir_d   = dir_q + 2'd1;
                sign_d  = 1'b0;
                count_d = 3'd1;
            end
        end

        if (new_game) begin
            state_d     = ST_IDLE;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
`ifdef WIN_SCAN_DRAW_EN
            drop_d      = 7'd0;
`endif
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            org_row_q   <= 3'd0;
            org_col_q   <= 3'd0;
            player_q    <= 2'b00;
            count_q     <= 3'd0;
            k_q         <= 3'd0;
            dir_q       <= 2'd0;
            sign_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
`ifdef WIN_SCAN_DRAW_EN
            drop_q      <= 7'd0;
`endif
        end else begin
            state_q     <= state_d;
            org_row_q   <= org_row_d;
            org_col_q   <= org_col_d;
            player_q    <= player_d;
            count_q     <= count_d;
            k_q         <= k_d;
            dir_q       <= dir_d;
            sign_q      <= sign_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
`ifdef WIN_SCAN_DRAW_EN
            drop_q      <= drop_d;
`endif
        end
    end

endmodule
`default_nettype wire
